// File: rtl/aurras_conv_pkg.sv
// Shared types and widths for the impulse-response convolver.
// Lane vectors carry the eight bank ports returned per cycle.
package aurras_conv_pkg;

  localparam int NUM_LANES  = 8;
  localparam int BANK_DEPTH = 6000;
  localparam int SAMPLE_W   = 16;
  localparam int INDEX_W    = 13;

  localparam int PROD_W = 2 * SAMPLE_W;
  localparam int A1_W   = PROD_W + 1;
  localparam int SUM_W  = PROD_W + 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } conv_state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t [NUM_LANES-1:0] lane_vec_t;

endpackage

// File: rtl/conv_mac_tree.sv
// Eight-lane multiply and two-level adder tree, three register stages.
// A flush drops every in-flight valid without touching the data path.
module conv_mac_tree
  import aurras_conv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  input  lane_vec_t               ir_vals,
  input  lane_vec_t               hist_vals,
  output logic                    out_valid,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [PROD_W-1:0] prod_q [NUM_LANES];
  logic signed [A1_W-1:0]   a1_q   [NUM_LANES/2];
  logic [2:0]               vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[1:0], in_valid};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        prod_q[i] <= '0;
      end
      for (int k = 0; k < NUM_LANES/2; k++) begin
        a1_q[k] <= '0;
      end
      sum <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        prod_q[i] <= PROD_W'(ir_vals[i])
                   * PROD_W'(hist_vals[i]);
      end
      for (int k = 0; k < NUM_LANES/2; k++) begin
        a1_q[k] <= A1_W'(prod_q[2*k])
                 + A1_W'(prod_q[2*k+1]);
      end
      sum <= SUM_W'(a1_q[0]) + SUM_W'(a1_q[1])
           + SUM_W'(a1_q[2]) + SUM_W'(a1_q[3]);
    end
  end

  assign out_valid = vld_q[2];

endmodule

// File: rtl/ir_convolver.sv
// Sweeps the IR banks once per audio sample and accumulates the
// 8-lane IR x history products into one rounded, saturated sample.
module ir_convolver
  import aurras_conv_pkg::*;
#(
  parameter int NUM_PAIRS   = BANK_DEPTH / 2,
  parameter int RAM_LATENCY = 2,
  parameter int ACC_WIDTH   = 48,
  parameter int OUT_SHIFT   = 15
) (
  input  logic               audio_clk,
  input  logic               rst_n_in,
  input  logic               sample_valid_in,
  input  logic               ir_load_active_in,
  input  lane_vec_t          ir_vals_in,
  input  lane_vec_t          hist_vals_in,
  output logic [INDEX_W-1:0] first_ir_index_out,
  output logic [INDEX_W-1:0] second_ir_index_out,
  output logic               busy_out,
  output sample_t            sample_out,
  output logic               sample_valid_out,
  output logic               overrun_out
);

  localparam int CNT_W  = $clog2(NUM_PAIRS + 1);
  localparam int LAST_D = RAM_LATENCY + 3;

  localparam logic signed [ACC_WIDTH-1:0] RND =
    ACC_WIDTH'(2 ** (OUT_SHIFT - 1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    ACC_WIDTH'(-32768);

  conv_state_t state_q;
  conv_state_t state_d;
  logic        start;
  logic        abort;
  logic        advance;
  logic        at_last;

  logic [CNT_W-1:0]       pair_q;
  logic                   issue_vld;
  logic                   issue_last;
  logic [RAM_LATENCY-1:0] ram_vld;
  logic [LAST_D-1:0]      last_sr;

  logic                    mac_vld;
  logic signed [SUM_W-1:0] mac_sum;

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        acc_done;
  logic signed [ACC_WIDTH-1:0] rnd;
  logic signed [ACC_WIDTH-1:0] shf;
  sample_t                     sat;

  assign at_last  = (pair_q == CNT_W'(NUM_PAIRS - 1));
  assign busy_out = (state_q != IDLE);
  assign advance  = (state_q == RUN) && (state_d == RUN);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_valid_in && !ir_load_active_in) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (ir_load_active_in) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (at_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ir_load_active_in) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (sample_valid_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Index outputs carry the pair currently issued; zero whenever idle.
  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pair_q              <= '0;
      first_ir_index_out  <= '0;
      second_ir_index_out <= '0;
      issue_vld           <= 1'b0;
      issue_last          <= 1'b0;
    end else begin
      unique case (1'b1)
        start: begin
          pair_q              <= '0;
          first_ir_index_out  <= '0;
          second_ir_index_out <= INDEX_W'(1);
          issue_vld           <= 1'b1;
          issue_last          <= (NUM_PAIRS == 1);
        end
        advance: begin
          pair_q              <= pair_q + CNT_W'(1);
          first_ir_index_out  <= first_ir_index_out + INDEX_W'(2);
          second_ir_index_out <= second_ir_index_out + INDEX_W'(2);
          issue_vld           <= 1'b1;
          issue_last          <= (pair_q == CNT_W'(NUM_PAIRS - 2));
        end
        default: begin
          pair_q              <= '0;
          first_ir_index_out  <= '0;
          second_ir_index_out <= '0;
          issue_vld           <= 1'b0;
          issue_last          <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ram_vld <= '0;
      last_sr <= '0;
    end else if (abort) begin
      ram_vld <= '0;
      last_sr <= '0;
    end else begin
      ram_vld <= {ram_vld[RAM_LATENCY-2:0], issue_vld};
      last_sr <= {last_sr[LAST_D-2:0], issue_last};
    end
  end

  conv_mac_tree u_mac (
    .clk       (audio_clk),
    .rst_n     (rst_n_in),
    .flush     (abort),
    .in_valid  (ram_vld[RAM_LATENCY-1]),
    .ir_vals   (ir_vals_in),
    .hist_vals (hist_vals_in),
    .out_valid (mac_vld),
    .sum       (mac_sum)
  );

  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q    <= '0;
      acc_done <= 1'b0;
    end else if (start || abort) begin
      acc_q    <= '0;
      acc_done <= 1'b0;
    end else begin
      if (mac_vld) begin
        acc_q <= acc_q + ACC_WIDTH'(mac_sum);
      end
      acc_done <= mac_vld && last_sr[LAST_D-1];
    end
  end

  // Round half up, then clamp to the 16-bit sample range.
  always_comb begin
    rnd = acc_q + RND;
    shf = rnd >>> OUT_SHIFT;
    sat = sample_t'(shf);
    if (shf > SAT_MAX) begin
      sat = sample_t'(16'h7FFF);
    end else if (shf < SAT_MIN) begin
      sat = sample_t'(16'h8000);
    end
  end

  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
    end else begin
      sample_valid_out <= acc_done && !abort;
      if (acc_done && !abort) begin
        sample_out <= sat;
      end
    end
  end

  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overrun_out <= 1'b0;
    end else if (sample_valid_in && busy_out && !ir_load_active_in) begin
      overrun_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_convolver.sv
// Scoreboard bench: bank/history model with two-cycle read latency,
// expected samples queued at request time and checked on each output pulse.
module tb_ir_convolver;
  import aurras_conv_pkg::*;

  localparam int NP  = 3000;
  localparam int LAT = NP + 2 + 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         svi;
  logic         load;
  lane_vec_t    ir_vals;
  lane_vec_t    hist_vals;
  logic [12:0]  first;
  logic [12:0]  second;
  logic         busy;
  sample_t      sout;
  logic         svo;
  logic         ovr;

  ir_convolver dut (
    .audio_clk           (clk),
    .rst_n_in            (rst_n),
    .sample_valid_in     (svi),
    .ir_load_active_in   (load),
    .ir_vals_in          (ir_vals),
    .hist_vals_in        (hist_vals),
    .first_ir_index_out  (first),
    .second_ir_index_out (second),
    .busy_out            (busy),
    .sample_out          (sout),
    .sample_valid_out    (svo),
    .overrun_out         (ovr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulses   = 0;
  int mode     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ir_f(input int m, input int i, input int a);
    case (m)
      0:       return (i == 0 && a == 0) ? 16384 : 0;
      1:       return 1;
      2, 3:    return 32767;
      default: return ((i * 37 + a * 13) % 2001) - 1000;
    endcase
  endfunction

  function automatic int hist_f(input int m, input int i, input int a);
    case (m)
      0:       return (i == 0) ? 1000 : 0;
      1, 2:    return 32767;
      3:       return -32768;
      default: return ((i * 11 + a * 7) % 401) - 200;
    endcase
  endfunction

  function automatic int model(input int m);
    longint acc;
    longint r;
    int     a;
    acc = 0;
    for (int j = 0; j < NP; j++) begin
      for (int i = 0; i < 8; i++) begin
        a = 2 * j + (i % 2);
        acc += longint'(ir_f(m, i, a)) * longint'(hist_f(m, i, a));
      end
    end
    r = (acc + 16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  logic [12:0] fa1 = '0;
  logic [12:0] fa2 = '0;
  logic [12:0] sa1 = '0;
  logic [12:0] sa2 = '0;

  always @(posedge clk) begin
    fa1 <= first;
    fa2 <= fa1;
    sa1 <= second;
    sa2 <= sa1;
  end

  always_comb begin
    ir_vals   = '0;
    hist_vals = '0;
    for (int i = 0; i < 8; i++) begin
      ir_vals[i] = sample_t'(ir_f(mode, i,
        (i % 2 == 0) ? int'(fa2) : int'(sa2)));
      hist_vals[i] = sample_t'(hist_f(mode, i,
        (i % 2 == 0) ? int'(fa2) : int'(sa2)));
    end
  end

  always @(negedge clk) begin
    if (svo === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("sample", sout, mon_e.val);
        chk("latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic req(input bit push, input int val, output int r);
    exp_t e;
    svi = 1'b1;
    r   = cyc;
    if (push) begin
      e.val = val;
      e.cyc = cyc + LAT;
      sb.push_back(e);
    end
    tick();
    svi = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < LAT + 100) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
    repeat (5) tick();
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    int p0;
    int o;
    int bad_busy;
    int bad_idx;
    int f_first;
    int s_first;
    int f_last;
    int s_last;
    int mix;

    rst_n = 1'b0;
    svi   = 1'b0;
    load  = 1'b0;
    mode  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sample", sout, 0);
    chk("rst_valid", svo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", ovr, 0);
    chk("rst_first", first, 0);
    chk("rst_second", second, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    mode = 0;
    p0 = pulses;
    req(1'b1, 500, r);
    wait_done("impulse_done");
    chk("impulse_pulses", pulses - p0, 1);

    mode = 1;
    p0 = pulses;
    req(1'b1, 23999, r);
    bad_busy = 0;
    bad_idx  = 0;
    f_first  = -1;
    s_first  = -1;
    f_last   = -1;
    s_last   = -1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      o = cyc - r;
      if (busy !== (o >= 1 && o <= LAT)) bad_busy++;
      if (o >= 1 && o <= NP) begin
        if (first !== 13'(2 * (o - 1)) || second !== 13'(2 * (o - 1) + 1))
          bad_idx++;
      end else if (first !== 13'd0 || second !== 13'd0) begin
        bad_idx++;
      end
      if (o == 1) begin
        f_first = int'(first);
        s_first = int'(second);
      end
      if (o == NP) begin
        f_last = int'(first);
        s_last = int'(second);
      end
    end
    chk("dc_busy_window", bad_busy, 0);
    chk("dc_index_seq", bad_idx, 0);
    chk("dc_first_pair_a", f_first, 0);
    chk("dc_first_pair_b", s_first, 1);
    chk("dc_last_pair_a", f_last, 5998);
    chk("dc_last_pair_b", s_last, 5999);
    wait_done("dc_done");
    chk("dc_pulses", pulses - p0, 1);

    mode = 2;
    req(1'b1, 32767, r);
    wait_done("sat_pos_done");

    mode = 3;
    req(1'b1, -32768, r);
    wait_done("sat_neg_done");

    mode = 1;
    p0 = pulses;
    req(1'b0, 0, r);
    goto(r + 1500);
    load = 1'b1;
    svi  = 1'b1;
    tick();
    svi = 1'b0;
    goto(r + 1502);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_first", first, 0);
    chk("abort_second", second, 0);
    goto(r + 1505);
    svi = 1'b1;
    tick();
    svi = 1'b0;
    @(negedge clk);
    chk("load_req_busy", busy, 0);
    chk("load_req_overrun", ovr, 0);
    repeat (5) tick();
    load = 1'b0;
    repeat (LAT + 20) tick();
    chk("abort_pulses", pulses - p0, 0);
    chk("abort_hold", sout, -32768);

    mode = 4;
    mix = model(4);
    p0 = pulses;
    req(1'b1, mix, r);
    wait_done("after_abort_done");
    chk("after_abort_pulses", pulses - p0, 1);

    mode = 1;
    p0 = pulses;
    req(1'b1, 23999, r);
    goto(r + 100);
    svi = 1'b1;
    @(negedge clk);
    chk("ovr_before", ovr, 0);
    tick();
    svi = 1'b0;
    @(negedge clk);
    chk("ovr_set", ovr, 1);
    wait_done("ovr_done");
    chk("ovr_pulses", pulses - p0, 1);
    chk("ovr_sticky", ovr, 1);

    mode = 1;
    req(1'b1, 23999, r);
    goto(r + 2000);
    rst_n = 1'b0;
    #1;
    chk("arst_sample", sout, 0);
    chk("arst_valid", svo, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", ovr, 0);
    chk("arst_first", first, 0);
    chk("arst_second", second, 0);
    sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    p0 = pulses;
    req(1'b1, 23999, r);
    wait_done("post_reset_done");
    chk("post_reset_pulses", pulses - p0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
